// File: rtl/acc_dump_vin_packer.sv
// acc_dump_vin_packer
//   Packs 32-bit accumulator samples into 256-bit words for the DDR
//   write-buffer stage. A frame is framed by acc_start_i. Samples fill
//   lanes 0..7 in order. The word is emitted when lane 7 fills, and any
//   partial word is flushed when the frame closes. laser_start_o then
//   stays high for TAIL_CYCLES extra cycles after the flush slot.
//
//   Optional feature: define ACC_DUMP_FRAME_HEADER_EN to emit a header word
//   {224'b0, HDR_MAGIC, frame_counter} at the start of each frame.
//
// Ports
//   ddr_clk_i        sole clock
//   ddr_rst_i        synchronous active-high reset
//   acc_start_i      frame gate, level-high for the whole frame
//   acc_vld_i        sample strobe
//   acc_data_i[31:0] sample data
//   laser_start_o    frame gate to the DDR write-buffer stage
//   laser_vld_o      one-cycle strobe per 256-bit word
//   laser_data_o     packed word; holds its value between strobes
//   frame_word_cnt_o words emitted in the current or last frame (saturating)
//   sample_drop_o    sticky flag; a sample arrived outside the packing window
module acc_dump_vin_packer #(
  parameter real         TCQ         = 0.1,
  parameter int unsigned TAIL_CYCLES = 4,
  parameter logic [15:0] HDR_MAGIC   = 16'hA5C3
) (
  input  logic         ddr_clk_i,
  input  logic         ddr_rst_i,
  input  logic         acc_start_i,
  input  logic         acc_vld_i,
  input  logic [31:0]  acc_data_i,
  output logic         laser_start_o,
  output logic         laser_vld_o,
  output logic [255:0] laser_data_o,
  output logic [15:0]  frame_word_cnt_o,
  output logic         sample_drop_o
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HEADER = 3'd1;
  localparam logic [2:0] PACK   = 3'd2;
  localparam logic [2:0] FLUSH  = 3'd3;
  localparam logic [2:0] TAIL   = 3'd4;

  localparam logic [3:0] TAIL_LAST = 4'(TAIL_CYCLES - 1);

  logic         r_start;
  logic         r_start_q;
  logic         r_vld;
  logic [31:0]  r_data;
  logic         rise;
  logic         fall;

  logic [2:0]   state;
  logic [2:0]   state_nx;
  logic [2:0]   lane_cnt;
  logic [3:0]   tail_cnt;
  logic [255:0] pack_buf;
  logic [255:0] filled;
  logic         packing;
  logic         take;
  logic [15:0]  cnt_inc;

`ifdef ACC_DUMP_FRAME_HEADER_EN
  logic [15:0]  hdr_cnt;
`endif

  // The start gate pipeline is deliberately not reset: it keeps tracking
  // acc_start_i through reset so that a frame still high when reset
  // releases is not mistaken for a fresh rise.
  always_ff @(posedge ddr_clk_i) begin
    r_start   <= acc_start_i;
    r_start_q <= r_start;
    r_data    <= acc_data_i;
  end

  always_ff @(posedge ddr_clk_i) begin
    if (ddr_rst_i) r_vld <= 1'b0;
    else           r_vld <= acc_vld_i;
  end

  assign rise    = r_start & ~r_start_q;
  assign fall    = ~r_start & r_start_q;
  assign packing = (state == PACK) || (state == HEADER);
  assign take    = packing & r_vld;
  assign cnt_inc = (frame_word_cnt_o == 16'hFFFF) ? frame_word_cnt_o
                                                  : frame_word_cnt_o + 16'd1;

  always_comb begin
    filled = pack_buf;
    filled[{lane_cnt, 5'd0} +: 32] = r_data;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (rise) begin
`ifdef ACC_DUMP_FRAME_HEADER_EN
          state_nx = HEADER;
`else
          state_nx = PACK;
`endif
        end
      end
      HEADER:  state_nx = PACK;
      PACK:    if (fall) state_nx = FLUSH;
      FLUSH:   state_nx = TAIL;
      TAIL:    if (tail_cnt == TAIL_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ddr_clk_i) begin
    if (ddr_rst_i) begin
      state            <= IDLE;
      lane_cnt         <= '0;
      tail_cnt         <= '0;
      pack_buf         <= '0;
      laser_start_o    <= 1'b0;
      laser_vld_o      <= 1'b0;
      laser_data_o     <= '0;
      frame_word_cnt_o <= '0;
      sample_drop_o    <= 1'b0;
`ifdef ACC_DUMP_FRAME_HEADER_EN
      hdr_cnt          <= '0;
`endif
    end else begin
      state         <= state_nx;
      laser_start_o <= (state_nx != IDLE);
      laser_vld_o   <= 1'b0;

      if ((state == IDLE) && rise) begin
        frame_word_cnt_o <= '0;
        pack_buf         <= '0;
        lane_cnt         <= '0;
      end

`ifdef ACC_DUMP_FRAME_HEADER_EN
      // lane_cnt is 0 on entry to HEADER, so a data word can never
      // complete in the same cycle as the header word.
      if (state == HEADER) begin
        laser_vld_o      <= 1'b1;
        laser_data_o     <= {224'd0, HDR_MAGIC, hdr_cnt};
        frame_word_cnt_o <= cnt_inc;
        hdr_cnt          <= hdr_cnt + 16'd1;
      end
`endif

      if (take) begin
        lane_cnt <= lane_cnt + 3'd1;
        if (lane_cnt == 3'd7) begin
          laser_vld_o      <= 1'b1;
          laser_data_o     <= filled;
          frame_word_cnt_o <= cnt_inc;
          pack_buf         <= '0;
        end else begin
          pack_buf <= filled;
        end
      end

      if (state == FLUSH) begin
        tail_cnt <= '0;
        lane_cnt <= '0;
        pack_buf <= '0;
        if (lane_cnt != 3'd0) begin
          laser_vld_o      <= 1'b1;
          laser_data_o     <= pack_buf;
          frame_word_cnt_o <= cnt_inc;
        end
      end

      if (state == TAIL) tail_cnt <= tail_cnt + 4'd1;

      if (r_vld && !packing) sample_drop_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_acc_dump_vin_packer.sv
module tb_acc_dump_vin_packer;

  localparam int unsigned TAIL_CYCLES = 4;
  localparam logic [15:0] HDR_MAGIC   = 16'hA5C3;

  logic         ddr_clk_i = 1'b0;
  logic         ddr_rst_i;
  logic         acc_start_i;
  logic         acc_vld_i;
  logic [31:0]  acc_data_i;
  logic         laser_start_o;
  logic         laser_vld_o;
  logic [255:0] laser_data_o;
  logic [15:0]  frame_word_cnt_o;
  logic         sample_drop_o;

  acc_dump_vin_packer #(
    .TCQ         (0.1),
    .TAIL_CYCLES (TAIL_CYCLES),
    .HDR_MAGIC   (HDR_MAGIC)
  ) dut (
    .ddr_clk_i        (ddr_clk_i),
    .ddr_rst_i        (ddr_rst_i),
    .acc_start_i      (acc_start_i),
    .acc_vld_i        (acc_vld_i),
    .acc_data_i       (acc_data_i),
    .laser_start_o    (laser_start_o),
    .laser_vld_o      (laser_vld_o),
    .laser_data_o     (laser_data_o),
    .frame_word_cnt_o (frame_word_cnt_o),
    .sample_drop_o    (sample_drop_o)
  );

  always #5 ddr_clk_i = ~ddr_clk_i;

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected words in emission order, plus the samples of the
  // word currently being assembled by the reference model.
  logic [255:0] exp_q[$];
  logic [31:0]  pend[$];
  logic [15:0]  hdr_seq     = 16'd0;
  int           frame_words = 0;
  logic         exp_drop    = 1'b0;

  int unsigned edge_cnt = 0;
  int unsigned lat_edge = 0;
  bit          lat_pending = 1'b0;

  always @(posedge ddr_clk_i) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge ddr_clk_i) begin
    if (laser_vld_o === 1'b1) begin
      if (lat_pending) begin
        lat_pending = 1'b0;
        check("vld_latency", 256'(edge_cnt), 256'(lat_edge));
      end
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word actual=%0h required=none", laser_data_o);
      end else begin
        check("word", laser_data_o, exp_q.pop_front());
      end
    end
  end

  function automatic logic [255:0] take_pending();
    logic [255:0] w;
    w = '0;
    for (int j = 0; j < pend.size(); j++) w[32*j +: 32] = pend[j];
    pend.delete();
    return w;
  endfunction

  task automatic drive(input logic s, input logic v, input logic [31:0] d);
    @(posedge ddr_clk_i);
    #1;
    acc_start_i = s;
    acc_vld_i   = v;
    acc_data_i  = d;
  endtask

  task automatic open_frame();
    frame_words = 0;
`ifdef ACC_DUMP_FRAME_HEADER_EN
    exp_q.push_back({224'd0, HDR_MAGIC, hdr_seq});
    hdr_seq++;
    frame_words = 1;
`endif
    drive(1'b1, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
  endtask

  task automatic put_sample(input logic [31:0] d, input logic fall_now, input bit lat);
    drive(~fall_now, 1'b1, d);
    pend.push_back(d);
    if (pend.size() == 8) begin
      exp_q.push_back(take_pending());
      frame_words++;
      if (lat) begin
        lat_edge    = edge_cnt + 2;
        lat_pending = 1'b1;
      end
    end
  endtask

  // Waits until laser_start_o drops, counting edges from the one that samples
  // the closing start edge. Optionally pokes a sample plus a restart pulse
  // into the tail window.
  task automatic wait_idle(input bit tail_poke);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 50) begin
      @(posedge ddr_clk_i);
      #1;
      n++;
      acc_vld_i  = 1'b0;
      acc_data_i = 32'd0;
      if (tail_poke) begin
        if (n == 2 || n == 3) begin
          acc_start_i = 1'b1;
          acc_vld_i   = 1'b1;
          acc_data_i  = $urandom;
          exp_drop    = 1'b1;
        end else begin
          acc_start_i = 1'b0;
        end
      end
      if (laser_start_o === 1'b0) done = 1'b1;
    end
    check("start_low_cycles", 256'(n), 256'(TAIL_CYCLES + 3));
  endtask

  // mode 0: sample values base, base+1, ...; mode 1: random values.
  task automatic run_frame(input int n, input bit fall_last, input bit gaps,
                           input bit lat, input logic [31:0] base, input int mode,
                           input bit tail_poke);
    logic [31:0] d;
    open_frame();
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) drive(1'b1, 1'b0, $urandom);
      end
      d = (mode == 0) ? base + 32'(i) : $urandom;
      put_sample(d, fall_last && (i == n - 1), lat);
    end
    if (!fall_last) drive(1'b0, 1'b0, 32'd0);
    if (pend.size() > 0) begin
      exp_q.push_back(take_pending());
      frame_words++;
    end
    wait_idle(tail_poke);
    check("frame_word_cnt", 256'(frame_word_cnt_o), 256'(frame_words));
    check("queue_drained", 256'(exp_q.size()), 256'd0);
    check("sample_drop", 256'(sample_drop_o), 256'(exp_drop));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    ddr_rst_i   = 1'b1;
    acc_start_i = 1'b0;
    acc_vld_i   = 1'b0;
    acc_data_i  = 32'd0;
    repeat (3) @(posedge ddr_clk_i);
    #1;
    check("rst_start", 256'(laser_start_o), 256'd0);
    check("rst_vld", 256'(laser_vld_o), 256'd0);
    check("rst_data", laser_data_o, 256'd0);
    check("rst_cnt", 256'(frame_word_cnt_o), 256'd0);
    check("rst_drop", 256'(sample_drop_o), 256'd0);
    ddr_rst_i = 1'b0;
    repeat (2) @(posedge ddr_clk_i);

    // Eight consecutive samples 1..8, latency checked on the full word.
    run_frame(8, 1'b0, 1'b0, 1'b1, 32'h1, 0, 1'b0);
    // Eleven samples: one full word plus a three-lane partial word.
    run_frame(11, 1'b0, 1'b0, 1'b0, 32'hA0, 0, 1'b0);
    // Eighth sample arrives on the closing edge of the gate.
    run_frame(8, 1'b1, 1'b0, 1'b0, 32'h100, 0, 1'b0);

    for (int f = 0; f < 6; f++)
      run_frame(int'($urandom_range(1, 30)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 32'd0, 1, 1'b0);

    // Sample and restart pulse inside the tail window.
    run_frame(5, 1'b0, 1'b0, 1'b0, 32'h500, 0, 1'b1);
    repeat (6) begin
      @(posedge ddr_clk_i);
      #1;
      check("restart_ignored", 256'(laser_start_o), 256'd0);
    end
    check("drop_sticky", 256'(sample_drop_o), 256'd1);

    // Reset in the middle of a frame after five samples.
    open_frame();
    for (int i = 0; i < 5; i++) put_sample($urandom, 1'b0, 1'b0);
    @(posedge ddr_clk_i);
    #1;
    ddr_rst_i = 1'b1;
    acc_vld_i = 1'b0;
    pend.delete();
    @(posedge ddr_clk_i);
    #1;
    ddr_rst_i = 1'b0;
    exp_drop  = 1'b0;
    hdr_seq   = 16'd0;
    check("mid_rst_start", 256'(laser_start_o), 256'd0);
    check("mid_rst_vld", 256'(laser_vld_o), 256'd0);
    check("mid_rst_data", laser_data_o, 256'd0);
    check("mid_rst_cnt", 256'(frame_word_cnt_o), 256'd0);
    check("mid_rst_drop", 256'(sample_drop_o), 256'd0);
    repeat (5) begin
      @(posedge ddr_clk_i);
      #1;
      check("no_start_after_rst", 256'(laser_start_o), 256'd0);
    end
    drive(1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 32'd0);

    for (int f = 0; f < 2; f++)
      run_frame(int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 32'd0, 1, 1'b0);

    repeat (4) @(posedge ddr_clk_i);
    check("final_queue_drained", 256'(exp_q.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
